// File: rtl/game_pkg.sv
// Shared types and constants for the game-round timer blocks.
// Latency: n/a (types, constants and constant functions only); backpressure: none.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } timer_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [3:0] BCD_NINE   = 4'd9;
    localparam int         MAX_DIGITS = 9;

    function automatic int bcd_max(input int digits);
        int r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
        logic [4*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit computing digit + addend + carry - (dec | borrow) in a single step.
// Latency: 1 cycle from i_update to o_digit; backpressure: none.
module bcd_digit
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_update,
    input  logic       i_sat,
    input  logic [3:0] i_add,
    input  logic       i_carry_in,
    input  logic       i_dec,
    input  logic       i_borrow_in,
    output logic [3:0] o_digit,
    output logic       o_carry_out,
    output logic       o_borrow_out
);

    logic [3:0] r_digit;
    logic [4:0] w_sum;
    logic [4:0] w_net;
    logic [3:0] w_next;
    logic       w_sub;
    logic       w_borrow;
    logic       w_carry;

    // Net digit value spans -1..19: one borrow or one carry, never both.
    always_comb begin
        w_sub    = i_dec | i_borrow_in;
        w_sum    = {1'b0, r_digit} + {1'b0, i_add} + {4'b0, i_carry_in};
        w_borrow = w_sub && (w_sum == 5'd0);
        w_net    = w_sum - {4'b0, w_sub};
        w_carry  = !w_borrow && (w_net >= 5'd10);
        if (w_borrow) begin
            w_next = BCD_NINE;
        end else if (w_carry) begin
            w_next = 4'(w_net - 5'd10);
        end else begin
            w_next = w_net[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_digit <= i_load_val;
        end else if (i_update) begin
            r_digit <= i_sat ? BCD_NINE : w_next;
        end
    end

    assign o_digit      = r_digit;
    assign o_carry_out  = w_carry;
    assign o_borrow_out = w_borrow;

endmodule

// File: rtl/countdown_ascii_timer.sv
// Round countdown timer: prescaled 1 s ticks, pause/resume, saturating bonus, ASCII digits.
// Latency: count/done register on the tick edge, ASCII/warn combinational from the count; backpressure: none.
module countdown_ascii_timer
    import game_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int START_VALUE = 31,
    parameter int TICK_DIV    = 100_000_000,
    parameter int BONUS       = 3,
    parameter int WARN_AT     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  bonus,
    input  logic                  restart,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [8*DIGITS-1:0]   time_ascii,
    output logic                  warn,
    output logic                  timer_done,
    output logic                  done_pulse
);

    localparam int MAX_COUNT = bcd_max(DIGITS);
    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [4*MAX_DIGITS-1:0] START_BCD = to_bcd(START_VALUE);
    localparam logic [4*MAX_DIGITS-1:0] BONUS_BCD = to_bcd(BONUS);

    generate
        if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
            $fatal(1, "countdown_ascii_timer: DIGITS out of range");
        end
        if (START_VALUE < 1 || START_VALUE > MAX_COUNT) begin : g_bad_start
            $fatal(1, "countdown_ascii_timer: START_VALUE out of range");
        end
        if (TICK_DIV < 1) begin : g_bad_div
            $fatal(1, "countdown_ascii_timer: TICK_DIV must be >= 1");
        end
        if (BONUS < 1 || BONUS > MAX_COUNT) begin : g_bad_bonus
            $fatal(1, "countdown_ascii_timer: BONUS out of range");
        end
    endgenerate

    timer_state_t      r_state;
    timer_state_t      w_state_nxt;
    logic [PW-1:0]     r_presc;
    logic              r_done_pulse;
    logic              w_count_en;
    logic              w_tick;
    logic              w_bonus_ok;
    logic              w_expire;
    logic              w_update;
    logic [DIGITS:0]   w_carry;
    logic [DIGITS:0]   w_borrow;
    int                w_count_bin;

    assign w_count_en = (r_state == ST_RUNNING) && !pause;
    assign w_tick     = w_count_en && (r_presc == PRESC_LAST);
    assign w_bonus_ok = bonus && ((r_state == ST_RUNNING) || (r_state == ST_PAUSED));
    assign w_expire   = w_tick && !w_bonus_ok && (w_count_bin == 1);
    // A borrow out of the top digit would mean ticking below zero; never commit it.
    assign w_update   = (w_tick || w_bonus_ok) && !w_borrow[DIGITS];

    assign w_carry[0]  = 1'b0;
    assign w_borrow[0] = 1'b0;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk          (clk),
                .rst          (rst),
                .i_load       (restart),
                .i_load_val   (START_BCD[4*i +: 4]),
                .i_update     (w_update),
                .i_sat        (w_carry[DIGITS]),
                .i_add        (w_bonus_ok ? BONUS_BCD[4*i +: 4] : 4'd0),
                .i_carry_in   (w_carry[i]),
                .i_dec        ((i == 0) ? w_tick : 1'b0),
                .i_borrow_in  (w_borrow[i]),
                .o_digit      (time_bcd[4*i +: 4]),
                .o_carry_out  (w_carry[i+1]),
                .o_borrow_out (w_borrow[i+1])
            );
            assign time_ascii[8*i +: 8] = ASCII_ZERO + {4'h0, time_bcd[4*i +: 4]};
        end
    endgenerate

    always_comb begin
        w_count_bin = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_count_bin = w_count_bin * 10 + int'(time_bcd[4*i +: 4]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (enable) w_state_nxt = ST_RUNNING;
            ST_RUNNING: begin
                if (w_expire) begin
                    w_state_nxt = ST_DONE;
                end else if (pause) begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED:  if (!pause && enable) w_state_nxt = ST_RUNNING;
            default:    w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_pulse <= w_expire;
            // Held outside RUNNING so a resumed second finishes its remaining cycles.
            if (w_count_en) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
        end
    end

    assign timer_done = (r_state == ST_DONE);
    assign done_pulse = r_done_pulse;
    assign warn       = (r_state != ST_DONE) && (w_count_bin != 0) && (w_count_bin <= WARN_AT);

endmodule

// File: tb/tb_countdown_ascii_timer.sv
// Directed bench for countdown_ascii_timer: three instances cover countdown/pause/warn/restart, expiry with TICK_DIV=1, and saturation.
// Expected values are hand-computed constants.
module tb_countdown_ascii_timer;

    logic clk = 1'b0;
    logic rst;
    logic en_a, pause_a, bonus_a, restart_a;
    logic en_b, pause_b, bonus_b, restart_b;
    logic en_c, pause_c, bonus_c, restart_c;
    logic [7:0]  bcd_a, bcd_b, bcd_c;
    logic [15:0] asc_a, asc_b, asc_c;
    logic warn_a, warn_b, warn_c;
    logic done_a, done_b, done_c;
    logic dp_a, dp_b, dp_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_ascii_timer #(.DIGITS(2), .START_VALUE(31), .TICK_DIV(4), .BONUS(3), .WARN_AT(5)) u_dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .pause(pause_a), .bonus(bonus_a), .restart(restart_a),
        .time_bcd(bcd_a), .time_ascii(asc_a), .warn(warn_a), .timer_done(done_a), .done_pulse(dp_a)
    );

    countdown_ascii_timer #(.DIGITS(2), .START_VALUE(2), .TICK_DIV(1), .BONUS(3), .WARN_AT(5)) u_dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .pause(pause_b), .bonus(bonus_b), .restart(restart_b),
        .time_bcd(bcd_b), .time_ascii(asc_b), .warn(warn_b), .timer_done(done_b), .done_pulse(dp_b)
    );

    countdown_ascii_timer #(.DIGITS(2), .START_VALUE(98), .TICK_DIV(16), .BONUS(3), .WARN_AT(5)) u_dut_c (
        .clk(clk), .rst(rst), .enable(en_c), .pause(pause_c), .bonus(bonus_c), .restart(restart_c),
        .time_bcd(bcd_c), .time_ascii(asc_c), .warn(warn_c), .timer_done(done_c), .done_pulse(dp_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {en_a, pause_a, bonus_a, restart_a} = '0;
        {en_b, pause_b, bonus_b, restart_b} = '0;
        {en_c, pause_c, bonus_c, restart_c} = '0;
        step(1);
        check_eq("a_rst_ascii", 32'(asc_a), 32'h3331);
        check_eq("a_rst_bcd",   32'(bcd_a), 32'h31);
        check_eq("a_rst_warn",  32'(warn_a), 32'd0);
        check_eq("a_rst_done",  32'(done_a), 32'd0);
        check_eq("a_rst_pulse", 32'(dp_a), 32'd0);
        check_eq("b_rst_bcd",   32'(bcd_b), 32'h02);
        check_eq("b_rst_warn",  32'(warn_b), 32'd1);
        check_eq("c_rst_bcd",   32'(bcd_c), 32'h98);
        rst = 1'b0;

        // A: countdown 31 -> 30 -> 29
        en_a = 1'b1;
        step(1);
        en_a = 1'b0;
        step(3);
        check_eq("a_pre_first_tick", 32'(asc_a), 32'h3331);
        step(1);
        check_eq("a_first_tick", 32'(asc_a), 32'h3330);
        step(4);
        check_eq("a_borrow_29", 32'(asc_a), 32'h3239);

        // A: pause two cycles into a second, hold ten, resume
        step(2);
        pause_a = 1'b1;
        step(10);
        check_eq("a_paused_hold", 32'(bcd_a), 32'h29);
        pause_a = 1'b0;
        en_a = 1'b1;
        step(1);
        en_a = 1'b0;
        step(1);
        check_eq("a_resume_wait", 32'(bcd_a), 32'h29);
        step(1);
        check_eq("a_resume_tick", 32'(bcd_a), 32'h28);

        // A: down to 09, bonus with carry -> 12
        step(76);
        check_eq("a_at_09", 32'(bcd_a), 32'h09);
        bonus_a = 1'b1;
        step(1);
        bonus_a = 1'b0;
        check_eq("a_bonus_carry", 32'(bcd_a), 32'h12);
        step(3);
        check_eq("a_after_bonus", 32'(bcd_a), 32'h11);

        // A: warning threshold and restart mid-second
        step(20);
        check_eq("a_at_06", 32'(bcd_a), 32'h06);
        check_eq("a_warn_06", 32'(warn_a), 32'd0);
        step(4);
        check_eq("a_at_05", 32'(bcd_a), 32'h05);
        check_eq("a_warn_05", 32'(warn_a), 32'd1);
        step(4);
        check_eq("a_at_04", 32'(bcd_a), 32'h04);
        step(2);
        restart_a = 1'b1;
        step(1);
        restart_a = 1'b0;
        check_eq("a_restart_ascii", 32'(asc_a), 32'h3331);
        check_eq("a_restart_warn", 32'(warn_a), 32'd0);
        check_eq("a_restart_done", 32'(done_a), 32'd0);
        step(8);
        check_eq("a_idle_hold", 32'(bcd_a), 32'h31);
        en_a = 1'b1;
        step(1);
        en_a = 1'b0;
        step(3);
        check_eq("a_presc_cleared", 32'(bcd_a), 32'h31);
        step(1);
        check_eq("a_restart_tick", 32'(bcd_a), 32'h30);

        // A: reset while paused at 17
        step(52);
        pause_a = 1'b1;
        step(1);
        check_eq("a_paused_17", 32'(bcd_a), 32'h17);
        step(3);
        check_eq("a_paused_17_hold", 32'(bcd_a), 32'h17);
        rst = 1'b1;
        step(1);
        check_eq("a_mid_rst_ascii", 32'(asc_a), 32'h3331);
        check_eq("a_mid_rst_warn", 32'(warn_a), 32'd0);
        check_eq("a_mid_rst_done", 32'(done_a), 32'd0);
        check_eq("a_mid_rst_pulse", 32'(dp_a), 32'd0);
        rst = 1'b0;
        pause_a = 1'b0;
        step(8);
        check_eq("a_mid_rst_idle", 32'(bcd_a), 32'h31);

        // B: TICK_DIV=1, tick+bonus at 1, then expiry
        en_b = 1'b1;
        step(1);
        en_b = 1'b0;
        check_eq("b_enable_edge", 32'(bcd_b), 32'h02);
        step(1);
        check_eq("b_at_01", 32'(bcd_b), 32'h01);
        bonus_b = 1'b1;
        step(1);
        bonus_b = 1'b0;
        check_eq("b_tick_bonus", 32'(bcd_b), 32'h03);
        check_eq("b_tick_bonus_done", 32'(done_b), 32'd0);
        check_eq("b_tick_bonus_pulse", 32'(dp_b), 32'd0);
        step(2);
        check_eq("b_back_01", 32'(bcd_b), 32'h01);
        step(1);
        check_eq("b_exp_ascii", 32'(asc_b), 32'h3030);
        check_eq("b_exp_done", 32'(done_b), 32'd1);
        check_eq("b_exp_pulse", 32'(dp_b), 32'd1);
        check_eq("b_exp_warn", 32'(warn_b), 32'd0);
        step(1);
        check_eq("b_pulse_once", 32'(dp_b), 32'd0);
        check_eq("b_done_level", 32'(done_b), 32'd1);
        en_b = 1'b1;
        bonus_b = 1'b1;
        step(3);
        en_b = 1'b0;
        bonus_b = 1'b0;
        check_eq("b_done_ignores", 32'(bcd_b), 32'h00);
        check_eq("b_done_stays", 32'(done_b), 32'd1);
        restart_b = 1'b1;
        step(1);
        restart_b = 1'b0;
        check_eq("b_restart_bcd", 32'(bcd_b), 32'h02);
        check_eq("b_restart_done", 32'(done_b), 32'd0);
        check_eq("b_restart_warn", 32'(warn_b), 32'd1);

        // B: restart on the would-be final tick suppresses DONE
        en_b = 1'b1;
        step(1);
        en_b = 1'b0;
        step(1);
        check_eq("b_again_01", 32'(bcd_b), 32'h01);
        restart_b = 1'b1;
        step(1);
        restart_b = 1'b0;
        check_eq("b_restart_wins", 32'(bcd_b), 32'h02);
        check_eq("b_restart_no_pulse", 32'(dp_b), 32'd0);
        check_eq("b_restart_no_done", 32'(done_b), 32'd0);
        step(3);
        check_eq("b_idle_after", 32'(bcd_b), 32'h02);

        // C: saturation at 99
        en_c = 1'b1;
        step(1);
        en_c = 1'b0;
        bonus_c = 1'b1;
        step(1);
        check_eq("c_sat_99", 32'(bcd_c), 32'h99);
        step(1);
        bonus_c = 1'b0;
        check_eq("c_sat_hold", 32'(bcd_c), 32'h99);
        step(13);
        check_eq("c_pre_tick", 32'(bcd_c), 32'h99);
        step(1);
        check_eq("c_tick_98", 32'(bcd_c), 32'h98);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
